// File: rtl/read_store_if.sv
// Bus bundle for read_store: load port, read-issue handshake and query channels.
interface read_store_if #(
    parameter int CL             = 512,
    parameter int READ_NUM_WIDTH = 8,
    parameter int NUM_QPORTS     = 2,
    parameter int QPOS_W         = 7
);
    logic                               stall;
    logic                               load_valid;
    logic [CL-1:0]                      load_data;
    logic [READ_NUM_WIDTH:0]            batch_size;
    logic                               batch_clear;
    logic                               load_done;
    logic                               load_overflow;
    logic                               new_read_valid;
    logic                               new_read_ready;
    logic [READ_NUM_WIDTH-1:0]          new_read_num;
    logic [63:0]                        new_ik_x0;
    logic [63:0]                        new_ik_x1;
    logic [63:0]                        new_ik_x2;
    logic [63:0]                        new_ik_info;
    logic [6:0]                         new_forward_i;
    logic [6:0]                         new_min_intv;
    logic [NUM_QPORTS-1:0]              query_valid;
    logic [NUM_QPORTS*QPOS_W-1:0]       query_position;
    logic [NUM_QPORTS*READ_NUM_WIDTH-1:0] query_read_num;
    logic [NUM_QPORTS-1:0]              query_out_valid;
    logic [NUM_QPORTS*8-1:0]            new_read_query;
    logic [63:0]                        primary;
    logic [63:0]                        L2_0;
    logic [63:0]                        L2_1;
    logic [63:0]                        L2_2;
    logic [63:0]                        L2_3;

    modport master (
        output stall, load_valid, load_data, batch_size, batch_clear,
               new_read_ready, query_valid, query_position, query_read_num,
        input  load_done, load_overflow, new_read_valid, new_read_num,
               new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info,
               new_forward_i, new_min_intv, query_out_valid, new_read_query,
               primary, L2_0, L2_1, L2_2, L2_3
    );

    modport slave (
        input  stall, load_valid, load_data, batch_size, batch_clear,
               new_read_ready, query_valid, query_position, query_read_num,
        output load_done, load_overflow, new_read_valid, new_read_num,
               new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info,
               new_forward_i, new_min_intv, query_out_valid, new_read_query,
               primary, L2_0, L2_1, L2_2, L2_3
    );
endinterface

// File: rtl/read_store.sv
// read_store: batch read buffer. Loads reads from host cache lines, issues
// them one at a time over a valid/ready handshake, and serves byte lookups
// on NUM_QPORTS independent three-stage extraction channels.
module read_store #(
    parameter int CL             = 512,
    parameter int READ_NUM_WIDTH = 8,
    parameter int READ_LINES     = 2,
    parameter int NUM_QPORTS     = 2,
    parameter int QPOS_W         = $clog2(READ_LINES * CL / 8)
) (
    input logic         clk,
    input logic         reset_n,
    read_store_if.slave bus
);
    localparam int RW       = READ_NUM_WIDTH;
    localparam int MAX_READ = 1 << RW;
    localparam int BYTE_W   = $clog2(CL / 8);
    localparam int HALF     = CL / 2;
    localparam int SA_W     = $clog2(MAX_READ * READ_LINES);
    localparam int LC_W     = $clog2(READ_LINES + 2);

    // Sequence lines, packed parameter fields {line[191:128], min_intv, forward_i}, ik lines.
    logic [CL-1:0] seq_mem [MAX_READ*READ_LINES];
    logic [77:0]   par_mem [MAX_READ];
    logic [CL-1:0] ik_mem  [MAX_READ];

    logic [LC_W-1:0] line_q, line_d;
    logic [RW:0]     cnt_q, cnt_d;
    logic [RW:0]     ptr_q, ptr_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            nrv;
    logic            wr_en;
    logic [SA_W-1:0] wr_sa;

    assign nrv   = done_q && (ptr_q < cnt_q);
    assign wr_en = bus.load_valid && !bus.batch_clear && !done_q;
    assign wr_sa = SA_W'(cnt_q[RW-1:0] * READ_LINES + line_q);

    // Next state of the load/issue counters; batch_clear wins over any beat.
    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        done_d = done_q | ((cnt_q == bus.batch_size) && (cnt_q != '0));
        ovf_d  = ovf_q;
        if (bus.batch_clear) begin
            line_d = '0;
            cnt_d  = '0;
            ptr_d  = '0;
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end else begin
            if (bus.load_valid) begin
                if (done_q) begin
                    ovf_d = 1'b1;
                end else if (line_q == LC_W'(READ_LINES + 1)) begin
                    line_d = '0;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
            if (nrv && bus.new_read_ready && !bus.stall) begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage writes, steered by the line position within the current read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (line_q < LC_W'(READ_LINES)) begin
                seq_mem[wr_sa] <= bus.load_data;
            end else if (line_q == LC_W'(READ_LINES)) begin
                par_mem[cnt_q[RW-1:0]] <= {bus.load_data[191:128], bus.load_data[70:64],
                                           bus.load_data[6:0]};
            end else begin
                ik_mem[cnt_q[RW-1:0]] <= bus.load_data;
            end
        end
    end

    assign bus.load_done      = done_q;
    assign bus.load_overflow  = ovf_q;
    assign bus.new_read_valid = nrv;

    // Offered read fields, with fixed filler values while nothing is offered.
    always_comb begin
        bus.new_read_num  = '1;
        bus.new_ik_x0     = {16{4'h1}};
        bus.new_ik_x1     = {16{4'h1}};
        bus.new_ik_x2     = {16{4'h1}};
        bus.new_ik_info   = {16{4'h1}};
        bus.new_forward_i = 7'h7F;
        bus.new_min_intv  = 7'h7F;
        if (nrv) begin
            bus.new_read_num  = ptr_q[RW-1:0];
            bus.new_ik_x0     = ik_mem[ptr_q[RW-1:0]][63:0];
            bus.new_ik_x1     = ik_mem[ptr_q[RW-1:0]][127:64];
            bus.new_ik_x2     = ik_mem[ptr_q[RW-1:0]][191:128];
            bus.new_ik_info   = ik_mem[ptr_q[RW-1:0]][255:192];
            bus.new_forward_i = par_mem[ptr_q[RW-1:0]][6:0];
            bus.new_min_intv  = par_mem[ptr_q[RW-1:0]][13:7];
        end
    end

    assign bus.primary = par_mem[0][77:14];
    assign bus.L2_0    = ik_mem[0][319:256];
    assign bus.L2_1    = ik_mem[0][383:320];
    assign bus.L2_2    = ik_mem[0][447:384];
    assign bus.L2_3    = ik_mem[0][511:448];

    for (genvar c = 0; c < NUM_QPORTS; c++) begin : g_q
        logic [QPOS_W-1:0] pos;
        logic [RW-1:0]     rn;
        logic [QPOS_W-1:0] qline;
        logic              miss;
        logic [SA_W-1:0]   rd_sa;
        logic [CL-1:0]     row;
        logic              vld_p1_q, vld_p2_q, vld_p3_q;
        logic              miss_p1_q, miss_p2_q;
        logic [HALF-1:0]   half_p1_q;
        logic [BYTE_W-2:0] bo_p1_q;
        logic [63:0]       word_p2_q;
        logic [2:0]        bb_p2_q;
        logic [7:0]        byte_p3_q;

        assign pos   = bus.query_position[c*QPOS_W +: QPOS_W];
        assign rn    = bus.query_read_num[c*RW +: RW];
        assign qline = pos >> BYTE_W;
        assign miss  = ({1'b0, rn} >= cnt_q) || (qline >= QPOS_W'(READ_LINES));
        assign rd_sa = SA_W'(rn * READ_LINES + qline);
        assign row   = seq_mem[rd_sa];

        // Valid chain and the result byte, frozen by stall.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_p1_q  <= 1'b0;
                vld_p2_q  <= 1'b0;
                vld_p3_q  <= 1'b0;
                byte_p3_q <= 8'hFF;
            end else if (!bus.stall) begin
                vld_p1_q  <= bus.query_valid[c];
                vld_p2_q  <= vld_p1_q;
                vld_p3_q  <= vld_p2_q;
                // S3: pick the byte, or 0xFF for a bubble or out-of-batch read
                byte_p3_q <= (vld_p2_q && !miss_p2_q) ? word_p2_q[bb_p2_q*8 +: 8] : 8'hFF;
            end
        end

        // Extraction datapath: half line, then 64-bit word, then byte offset.
        always_ff @(posedge clk) begin
            if (!bus.stall) begin
                // S1: half line selected by the line and half bits
                miss_p1_q <= miss;
                half_p1_q <= pos[BYTE_W-1] ? row[CL-1 -: HALF] : row[HALF-1:0];
                bo_p1_q   <= pos[BYTE_W-2:0];
                // S2: 64-bit word within the half
                miss_p2_q <= miss_p1_q;
                word_p2_q <= half_p1_q[(bo_p1_q >> 3) * 64 +: 64];
                bb_p2_q   <= bo_p1_q[2:0];
            end
        end

        assign bus.query_out_valid[c]      = vld_p3_q;
        assign bus.new_read_query[c*8 +: 8] = byte_p3_q;
    end
endmodule

// File: tb/tb_read_store.sv
// Directed/randomised bench for read_store with a byte-level reference model.
module tb_read_store;
    localparam int CL = 512;
    localparam int RW = 8;
    localparam int RL = 2;
    localparam int NQ = 2;
    localparam int QW = 7;
    localparam int LB = CL / 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    read_store_if #(.CL(CL), .READ_NUM_WIDTH(RW), .NUM_QPORTS(NQ), .QPOS_W(QW)) bus ();

    read_store #(.CL(CL), .READ_NUM_WIDTH(RW), .READ_LINES(RL), .NUM_QPORTS(NQ),
                 .QPOS_W(QW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Reference contents: what each read's lines hold, and how many reads are loaded.
    logic [CL-1:0] m_seq [4][RL];
    logic [CL-1:0] m_par [4];
    logic [CL-1:0] m_ik  [4];
    int            m_cnt;

    logic [7:0] ev [16][NQ];
    logic [7:0] eb [16][NQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CL-1:0] rnd_line();
        logic [CL-1:0] v;
        for (int i = 0; i < CL / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Byte p of read r: plain byte addressing over the read's sequence lines.
    function automatic logic [7:0] q_exp(int r, int p);
        logic [CL-1:0] ln;
        if (r >= m_cnt) return 8'hFF;
        ln = m_seq[r][p / LB];
        return ln[(p % LB) * 8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [CL-1:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        step();
        bus.load_valid = 1'b0;
    endtask

    task automatic load_read(input int r);
        for (int l = 0; l < RL; l++) begin
            m_seq[r][l] = rnd_line();
            beat(m_seq[r][l]);
        end
        m_par[r] = rnd_line();
        beat(m_par[r]);
        m_ik[r] = rnd_line();
        beat(m_ik[r]);
        m_cnt = r + 1;
    endtask

    task automatic chk_offer(input int r);
        logic [7:0] rn;
        if (r >= 0) begin
            rn = r[7:0];
            chk($sformatf("nr_valid[r%0d]", r), {63'd0, bus.new_read_valid}, 64'd1);
            chk($sformatf("nr_num[r%0d]", r), {56'd0, bus.new_read_num}, {56'd0, rn});
            chk($sformatf("ik_x0[r%0d]", r), bus.new_ik_x0, m_ik[r][63:0]);
            chk($sformatf("ik_x1[r%0d]", r), bus.new_ik_x1, m_ik[r][127:64]);
            chk($sformatf("ik_x2[r%0d]", r), bus.new_ik_x2, m_ik[r][191:128]);
            chk($sformatf("ik_info[r%0d]", r), bus.new_ik_info, m_ik[r][255:192]);
            chk($sformatf("fwd[r%0d]", r), {57'd0, bus.new_forward_i}, {57'd0, m_par[r][6:0]});
            chk($sformatf("min_intv[r%0d]", r), {57'd0, bus.new_min_intv}, {57'd0, m_par[r][70:64]});
        end else begin
            chk("nr_valid_idle", {63'd0, bus.new_read_valid}, 64'd0);
            chk("nr_num_idle", {56'd0, bus.new_read_num}, 64'hFF);
            chk("ik_x0_idle", bus.new_ik_x0, 64'h1111_1111_1111_1111);
            chk("ik_info_idle", bus.new_ik_info, 64'h1111_1111_1111_1111);
            chk("fwd_idle", {57'd0, bus.new_forward_i}, 64'h7F);
            chk("min_idle", {57'd0, bus.new_min_intv}, 64'h7F);
        end
    endtask

    task automatic chk_r0_lines(input string tag);
        chk({tag, "_primary"}, bus.primary, m_par[0][191:128]);
        chk({tag, "_L2_0"}, bus.L2_0, m_ik[0][319:256]);
        chk({tag, "_L2_1"}, bus.L2_1, m_ik[0][383:320]);
        chk({tag, "_L2_2"}, bus.L2_2, m_ik[0][447:384]);
        chk({tag, "_L2_3"}, bus.L2_3, m_ik[0][511:448]);
    endtask

    task automatic set_q(input int c, input logic v, input int r, input int p);
        bus.query_valid[c]              = v;
        bus.query_read_num[c*RW +: RW]  = RW'(r);
        bus.query_position[c*QW +: QW]  = QW'(p);
    endtask

    task automatic chk_q(input string tag, input int c, input logic v, input logic [7:0] b);
        chk($sformatf("%s_qvalid%0d", tag, c), {63'd0, bus.query_out_valid[c]}, {63'd0, v});
        chk($sformatf("%s_qbyte%0d", tag, c), {56'd0, bus.new_read_query[c*8 +: 8]}, {56'd0, b});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"}, {63'd0, bus.load_done}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, bus.load_overflow}, 64'd0);
        chk({tag, "_nrv"}, {63'd0, bus.new_read_valid}, 64'd0);
        chk({tag, "_qov"}, {62'd0, bus.query_out_valid}, 64'd0);
        chk({tag, "_query"}, {48'd0, bus.new_read_query}, 64'hFFFF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_ptr;
        int p0, p1, pa, pb;
        logic [CL-1:0] junk;
        bit rdy_tab [10];
        bit stl_tab [10];

        bus.stall = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data = '0;
        bus.batch_size = '0;
        bus.batch_clear = 1'b0;
        bus.new_read_ready = 1'b0;
        bus.query_valid = '0;
        bus.query_position = '0;
        bus.query_read_num = '0;
        m_cnt = 0;

        // Reset state
        repeat (2) step();
        chk_reset_outputs("rst");
        chk_offer(-1);
        #2 reset_n = 1'b1;
        step();

        // Batch of three reads, 12 beats back to back
        bus.batch_size = 9'd3;
        for (int r = 0; r < 3; r++) load_read(r);
        chk("done_early", {63'd0, bus.load_done}, 64'd0);
        step();
        chk("done_rise", {63'd0, bus.load_done}, 64'd1);
        chk_r0_lines("b1");

        // Issue: ready held low, then pulses; one pulse stalled
        rdy_tab = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        stl_tab = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        m_ptr = 0;
        for (int i = 0; i < 10; i++) begin
            bus.new_read_ready = rdy_tab[i];
            bus.stall = stl_tab[i];
            chk_offer(m_ptr < m_cnt ? m_ptr : -1);
            if (m_ptr < m_cnt && rdy_tab[i] && !stl_tab[i]) m_ptr++;
            step();
        end
        bus.new_read_ready = 1'b0;
        bus.stall = 1'b0;
        chk_offer(-1);

        // Two channels hit read 1 in the same cycle
        set_q(0, 1'b1, 1, 70);
        set_q(1, 1'b1, 1, 0);
        step();
        bus.query_valid = '0;
        chk({62'd0, bus.query_out_valid}, 64'd0, 64'd0) ;
        step();
        chk("q_t2_valid", {62'd0, bus.query_out_valid}, 64'd0);
        step();
        chk_q("q70", 0, 1'b1, q_exp(1, 70));
        chk_q("q0", 1, 1'b1, q_exp(1, 0));

        // Random stream on both channels, one request per cycle
        for (int k = 0; k < 14; k++) begin
            if (k < 12) begin
                for (int c = 0; c < NQ; c++) begin
                    logic v;
                    int r, p;
                    v = 1'($urandom_range(0, 1));
                    r = $urandom_range(0, 3);
                    p = $urandom_range(0, RL * LB - 1);
                    set_q(c, v, r, p);
                    ev[k][c] = {7'd0, v};
                    eb[k][c] = v ? q_exp(r, p) : 8'hFF;
                end
            end else begin
                bus.query_valid = '0;
            end
            step();
            if (k >= 2) begin
                for (int c = 0; c < NQ; c++)
                    chk_q($sformatf("rnd%0d", k - 2), c, ev[k-2][c][0], eb[k-2][c]);
            end
        end

        // Out-of-batch read plus a 2-cycle stall mid-pipeline
        p0 = $urandom_range(0, RL * LB - 1);
        p1 = $urandom_range(0, RL * LB - 1);
        set_q(0, 1'b1, 5, p0);
        set_q(1, 1'b1, 2, p1);
        step();
        bus.query_valid = '0;
        bus.stall = 1'b1;
        step();
        step();
        chk("stall_hold_qov", {62'd0, bus.query_out_valid}, 64'd0);
        bus.stall = 1'b0;
        step();
        chk("stall_t4_qov", {62'd0, bus.query_out_valid}, 64'd0);
        step();
        chk_q("miss5", 0, 1'b1, 8'hFF);
        chk_q("stalled", 1, 1'b1, q_exp(2, p1));

        // Extra beat after load_done
        beat(rnd_line());
        chk("ovf_set", {63'd0, bus.load_overflow}, 64'd1);
        chk("ovf_done_kept", {63'd0, bus.load_done}, 64'd1);
        chk_r0_lines("ovf");

        // batch_clear with a simultaneous beat; the beat must be dropped
        junk = rnd_line();
        bus.batch_clear = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data = junk;
        step();
        bus.batch_clear = 1'b0;
        bus.load_valid = 1'b0;
        m_cnt = 0;
        chk_reset_outputs("clr");
        bus.batch_size = 9'd2;
        load_read(0);
        load_read(1);
        step();
        chk("b2_done", {63'd0, bus.load_done}, 64'd1);
        chk_r0_lines("b2");
        chk_offer(0);
        pa = $urandom_range(0, RL * LB - 1);
        pb = $urandom_range(0, RL * LB - 1);
        set_q(0, 1'b1, 1, pa);
        set_q(1, 1'b1, 2, pb);
        step();
        bus.query_valid = '0;
        step();
        step();
        chk_q("b2q", 0, 1'b1, q_exp(1, pa));
        chk_q("b2miss", 1, 1'b1, 8'hFF);

        // Asynchronous reset in the middle of a load
        bus.batch_clear = 1'b1;
        step();
        bus.batch_clear = 1'b0;
        m_cnt = 0;
        load_read(0);
        for (int l = 0; l < RL; l++) begin
            m_seq[1][l] = rnd_line();
            beat(m_seq[1][l]);
        end
        pa = $urandom_range(0, RL * LB - 1);
        set_q(0, 1'b1, 0, pa);
        step();
        bus.query_valid = '0;
        step();
        step();
        chk_q("pre_rst", 0, 1'b1, q_exp(0, pa));
        #2 reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        m_cnt = 0;
        #2 reset_n = 1'b1;
        step();
        load_read(0);
        load_read(1);
        step();
        chk("reload_done", {63'd0, bus.load_done}, 64'd1);
        chk_r0_lines("reload");
        chk_offer(0);
        pa = $urandom_range(0, RL * LB - 1);
        pb = $urandom_range(0, RL * LB - 1);
        set_q(0, 1'b1, 1, pa);
        set_q(1, 1'b1, 0, pb);
        step();
        bus.query_valid = '0;
        step();
        step();
        chk_q("reload_q", 0, 1'b1, q_exp(1, pa));
        chk_q("reload_q", 1, 1'b1, q_exp(0, pb));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/read_store.md
# read_store

Multi-port, parametrised read buffer for the SMEM pipeline. Loads a batch of reads from host cache lines, hands reads one at a time to the forward pipeline with a valid/ready handshake, and serves base-query lookups on NUM_QPORTS independent 3-stage extraction channels. Adds three capabilities: configurable read length, multiple query channels, and batch clear/reload without reset.

## Interface
- CL, 512: cache-line width in bits; a power of two, at least 128.
- READ_NUM_WIDTH, 8: read index width; capacity MAX_READ = 2^READ_NUM_WIDTH.
- READ_LINES, 2: sequence lines per read; each read occupies READ_LINES+2 lines.
- NUM_QPORTS, 2: number of query channels.
- QPOS_W, derived: clog2(READ_LINES*CL/8), the query position width.
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  freezes the read-issue pointer and all query pipelines
- load_valid  in  1  load_data beat valid
- load_data  in  CL  load line
- batch_size  in  READ_NUM_WIDTH+1  number of reads in the batch
- batch_clear  in  1  synchronous batch restart
- load_done  out  1  batch fully loaded
- load_overflow  out  1  sticky: a beat arrived after load_done
- new_read_valid  out  1  a read is available
- new_read_ready  in  1  consumer accepts the read
- new_read_num  out  READ_NUM_WIDTH  index of the offered read
- new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info  out  64 each  initial interval of the offered read
- new_forward_i, new_min_intv  out  7 each  read parameters
- query_valid  in  NUM_QPORTS  per-channel request
- query_position  in  NUM_QPORTS*QPOS_W  packed byte positions, channel 0 in the LSBs
- query_read_num  in  NUM_QPORTS*READ_NUM_WIDTH  packed read indices
- query_out_valid  out  NUM_QPORTS  result valid
- new_read_query  out  NUM_QPORTS*8  result bytes
- primary  out  64  read 0 parameter line bits [191:128]
- L2_0, L2_1, L2_2, L2_3  out  64 each  read 0 ik line bits [319:256], [383:320], [447:384], [511:448]

## Operation
- Reset values: load_done=0, load_overflow=0, new_read_valid=0, query_out_valid=0, every byte of new_read_query=8'hFF.
- Internal counters reset to 0: line counter, read count, issue pointer. The storage RAMs are not reset.
- Loading ignores stall.
- Each accepted beat advances the line counter from 0 to READ_LINES+1, then wraps to 0.
  - Lines 0..READ_LINES-1 are stored as sequence lines. Bytes run from the LSB upward, so line k holds positions k*CL/8 onward.
  - Line READ_LINES is the parameter line: forward_i = [6:0], min_intv = [70:64].
  - Line READ_LINES+1 is the ik line: x0 = [63:0], x1 = [127:64], x2 = [191:128], info = [255:192]. Storing it increments the read count.
- load_done is registered. It is set the cycle after read count == batch_size, with count > 0.
- batch_size = 0 never completes.
- Once load_done=1, load_valid is ignored and sets load_overflow.
- batch_clear zeroes the counters, load_done and load_overflow. RAM contents persist.
  - batch_clear has priority over a simultaneous load_valid; that beat is dropped.
  - The query pipelines are not flushed.
- Read issue:
  - new_read_valid = load_done & (pointer < count), combinational.
  - The pointer increments when new_read_valid & new_read_ready & !stall.
  - While new_read_valid=0: new_read_num is all ones, ik outputs are 64'h1111_1111_1111_1111, and forward_i and min_intv are 7'h7F.
- Query channel, 3 stages, registered:
  - S1 latches the CL/2-bit half line selected by the position's line and half bits.
  - S2 latches the selected 64-bit word.
  - S3 latches the selected byte.
  - Valid travels with the data.
  - If the request has query_read_num >= count, or the stage is a bubble, the output byte is 8'hFF.
  - Channels are fully independent. Any number of channels may address the same read in the same cycle.
- primary and L2_* continuously reflect the RAM contents for read 0.

## Timing
- A query presented in cycle t, with stall low during t, t+1 and t+2, yields query_out_valid and its byte after edge t+2, i.e. visible in cycle t+3.
- While stall=1, every pipeline register and the issue pointer hold their values. Outputs hold.
- Issue throughput: one read per cycle. A handshake at edge t presents the next read combinationally in cycle t+1.
- load_done rises one cycle after the final ik beat.
- batch_clear takes effect at the next edge.
- A reset_n assertion mid-operation clears immediately and asynchronously. Loading restarts at line 0.

## Test plan
- Reset, then a 3-read batch with READ_LINES=2 (12 beats) -> load_done rises 1 cycle after beat 12. Reads 0, 1, 2 are then offered with the loaded ik and forward_i values, and new_read_valid drops after 3 handshakes.
- new_read_ready held low for 5 cycles, then pulsed; stall asserted during one pulse -> the pointer advances only on unstalled handshakes.
- Query channel 0, read 1, position 70 (line 1, byte 6) -> the matching byte appears in cycle t+3. Channel 1 in the same cycle, read 1, position 0 -> its correct byte appears in the same cycle.
- Query with read_num=5 on a 3-read batch -> query_out_valid=1 with byte 8'hFF. A 2-cycle stall mid-pipeline delays the result by exactly 2 cycles.
- Extra beat after load_done -> load_overflow=1 and contents unchanged. batch_clear together with load_valid -> counters zeroed, the beat dropped, and a second batch loads correctly.
- reset_n dropped mid-load after beat 6 -> all outputs return to their reset values asynchronously. A reload from beat 0 then succeeds.
